// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier family.
package booth_pkg;

   // Widest operand the extension helper supports.
   localparam int unsigned MaxW = 64;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Internal datapath width: one guard bit so unsigned and most-negative operands fit.
   function automatic int unsigned ext_width(input int unsigned width);
      return width + 1;
   endfunction

   // Extend a width-bit operand (zero above bit width-1) to MaxW+1 bits.
   function automatic logic [MaxW:0] ext_op(input logic [MaxW-1:0] value,
                                            input logic            is_signed,
                                            input int unsigned     width);
      logic [MaxW:0] hi_mask;
      logic          fill;
      hi_mask = {(MaxW + 1){1'b1}} << width;
      fill    = is_signed & (|(value & (MaxW'(1) << (width - 1))));
      return ({1'b0, value} & ~hi_mask) | (fill ? hi_mask : '0);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract followed by arithmetic right shift.
module booth_step #(
   parameter int unsigned E = 9
) (
   input  logic [E-1:0] a,
   input  logic [E-1:0] m,
   input  logic [E-1:0] q,
   input  logic         qm1,
   output logic [E-1:0] a_nxt,
   output logic [E-1:0] q_nxt,
   output logic         qm1_nxt
);

   logic [E-1:0] sum;

   always_comb begin
      case ({q[0], qm1})
         2'b01:   sum = a + m;
         2'b10:   sum = a - m;
         default: sum = a;
      endcase
   end

   // Shift {sum, q, qm1} right by one, replicating the sum's sign bit.
   assign a_nxt   = {sum[E-1], sum[E-1:1]};
   assign q_nxt   = {sum[0], q[E-1:1]};
   assign qm1_nxt = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes and zero-multiplier early exit.
// WIDTH must lie in [2, MaxW].
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_mcand,
   input  logic [WIDTH-1:0]     in_mplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic                 busy
);

   localparam int unsigned E  = ext_width(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   state_e          state_q, state_d;
   logic [E-1:0]    a_q, a_d, q_q, q_d, m_q, m_d;
   logic            qm1_q, qm1_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   prod_q, prod_d;

   logic [E-1:0]    a_nxt, q_nxt;
   logic            qm1_nxt;
   logic [E-1:0]    mcand_ext, mplier_ext;
   logic            accept, mplier_zero, last_step;

   assign accept      = in_valid && (state_q == StIdle);
   assign mplier_zero = (in_mplier == '0);
   assign last_step   = (count_q == CW'(1));
   assign mcand_ext   = E'(ext_op(MaxW'(in_mcand), in_signed, WIDTH));
   assign mplier_ext  = E'(ext_op(MaxW'(in_mplier), in_signed, WIDTH));

   booth_step #(
      .E (E)
   ) u_step (
      .a       (a_q),
      .m       (m_q),
      .q       (q_q),
      .qm1     (qm1_q),
      .a_nxt   (a_nxt),
      .q_nxt   (q_nxt),
      .qm1_nxt (qm1_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = mplier_zero ? StDone : StRun;
         StRun:  if (last_step) state_d = StDone;
         StDone: if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q == StRun) || (state_q == StDone);
      out_valid = (state_q == StDone);
      out_prod  = prod_q;
   end

   always_comb begin
      a_d     = a_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      count_d = count_q;
      prod_d  = prod_q;
      if (accept) begin
         a_d     = '0;
         q_d     = mplier_ext;
         qm1_d   = 1'b0;
         m_d     = mcand_ext;
         count_d = CW'(E);
         if (mplier_zero) prod_d = '0;
      end else if (state_q == StRun) begin
         a_d     = a_nxt;
         q_d     = q_nxt;
         qm1_d   = qm1_nxt;
         count_d = count_q - CW'(1);
         // The product fits in 2*WIDTH bits; the two guard bits are discarded.
         if (last_step) prod_d = PW'({a_nxt, q_nxt});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         count_q <= '0;
         prod_q  <= '0;
      end else begin
         a_q     <= a_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         count_q <= count_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases plus randomized operands vs. an integer model.
module tb_booth_mult_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic           in_signed;
   logic [W-1:0]   in_mcand;
   logic [W-1:0]   in_mplier;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_prod;
   logic           busy;

   int n_pass  = 0;
   int n_total = 0;

   booth_mult_seq #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_mcand  (in_mcand),
      .in_mplier (in_mplier),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: plain integer multiplication of the interpreted operands.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] mc, input logic [W-1:0] mp,
                                               input logic sg);
      longint x, y;
      x = sg ? longint'($signed(mc)) : longint'(mc);
      y = sg ? longint'($signed(mp)) : longint'(mp);
      return (2*W)'(x * y);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE, wait for the result, hold it `hold` cycles, then take it.
   task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic sg,
                         input int hold);
      logic [2*W-1:0] exp;
      int             lat;
      int             exp_lat;
      exp     = ref_prod(mc, mp, sg);
      exp_lat = (mp == '0) ? 1 : W + 2;
      check("ready_before_accept", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_signed = sg;
      in_mcand  = mc;
      in_mplier = mp;
      out_ready = 1'b0;
      step();
      lat = 1;
      // Operand inputs are scrambled while busy; they must have no effect.
      while (!out_valid && lat < 40) begin
         in_valid  = 1'($urandom);
         in_signed = 1'($urandom);
         in_mcand  = W'($urandom);
         in_mplier = W'($urandom);
         step();
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("product", 32'(out_prod), 32'(exp));
      check("busy_done", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         in_mcand = W'($urandom);
         step();
         check("held_valid", 32'(out_valid), 32'd1);
         check("held_prod", 32'(out_prod), 32'(exp));
         check("held_not_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("valid_cleared", 32'(out_valid), 32'd0);
      check("idle_after_take", 32'(in_ready), 32'd1);
      check("not_busy_after_take", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] mc, mp;
      logic         sg;

      // Reset with in_valid high: must not be accepted.
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_signed = 1'b1;
      in_mcand  = 8'h11;
      in_mplier = 8'h22;
      out_ready = 1'b0;
      step();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_prod", 32'(out_prod), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      step();
      check("no_accept_after_rst", 32'(busy), 32'd0);

      run_op(8'hFD, 8'h05, 1'b1, 0);
      check("neg3x5_const", 32'(out_prod), 32'h0000_FFF1);
      run_op(8'hFF, 8'hFF, 1'b0, 1);
      run_op(8'hFF, 8'hFF, 1'b1, 0);
      run_op(8'h80, 8'h80, 1'b1, 0);
      run_op(8'h7F, 8'h80, 1'b1, 0);
      run_op(8'h80, 8'h80, 1'b0, 0);
      run_op(8'h5A, 8'h00, 1'b0, 2);
      run_op(8'h12, 8'hC4, 1'b1, 20);

      // Abort mid-RUN; the result is dropped and the next op has no residue.
      in_valid  = 1'b1;
      in_signed = 1'b1;
      in_mcand  = 8'h64;
      in_mplier = 8'hB3;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_prod_cleared", 32'(out_prod), 32'd0);
      run_op(8'd7, 8'd6, 1'b0, 0);
      check("seven_six_const", 32'(out_prod), 32'h0000_002A);

      for (int n = 0; n < 40; n++) begin
         mc = W'($urandom);
         mp = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         sg = 1'($urandom);
         run_op(mc, mp, sg, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
